// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the single-outstanding memory responder.
// The state enum, widths and the address check are used by every block.
package dm_responder_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // A request errors when it is not word aligned or its word index is past the array.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || (addr[WORD_W-1:2] >= (WORD_W-2)'(depth));
   endfunction

endpackage

// File: rtl/dm_responder_ram.sv
// Word-wide storage for dm_responder: synchronous write, asynchronous read.
// Contents survive reset so committed stores persist across a reset pulse.
module dm_responder_ram
   import dm_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // NOTE: the array has no reset branch on purpose; clearing it would need a
   // per-word write port and would erase data that must outlive a reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding load/store responder: IDLE accepts, WAIT burns LATENCY
// cycles, RESP holds the response until the initiator takes it.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              accept;
   logic              enter_resp;
   logic              cur_write;
   logic [WORD_W-1:0] cur_addr;
   logic [WORD_W-1:0] cur_wdata;
   logic              cur_err;
   logic [AW-1:0]     cur_idx;
   logic              ram_we;
   logic [WORD_W-1:0] ram_rdata;

   assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

   // With LATENCY=0 the store commits on the accept edge itself, so the live
   // request is used there; otherwise the latched copy is.
   assign cur_write = accept ? req_write : write_q;
   assign cur_addr  = accept ? req_addr  : addr_q;
   assign cur_wdata = accept ? req_wdata : wdata_q;
   assign cur_err   = addr_err(cur_addr, DEPTH_WORDS);
   assign cur_idx   = cur_addr[AW+1:2];

   // NOTE: every signal assigned here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LATENCY > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
      ram_we     = enter_resp && cur_write && !cur_err;
      if (enter_resp) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = cur_err;
         rsp_rdata_d = (!cur_write && !cur_err) ? ram_rdata : '0;
      end

      req_ready_d = (state_d == ST_IDLE);
   end

   // NOTE: all state updates use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   dm_responder_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (cur_idx),
      .wdata (cur_wdata),
      .raddr (cur_idx),
      .rdata (ram_rdata)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed scoreboard bench for dm_responder: a LATENCY=2 instance for the
// main sequence and a LATENCY=0 instance for back-to-back throughput.
module tb_dm_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_req_valid, z_req_ready, z_req_write;
   logic [31:0] z_req_addr, z_req_wdata;
   logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [31:0] model [DEPTH];
   bit          junk_on = 1'b0;

   dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (z_req_valid),
      .req_ready (z_req_ready),
      .req_write (z_req_write),
      .req_addr  (z_req_addr),
      .req_wdata (z_req_wdata),
      .rsp_valid (z_rsp_valid),
      .rsp_ready (z_rsp_ready),
      .rsp_rdata (z_rsp_rdata),
      .rsp_err   (z_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request and return one cycle after the accept edge.
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input bit push);
      int   n = 0;
      exp_t e;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept_wait", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (junk_on) begin
         req_write = ~w;
         req_addr  = a;
         req_wdata = 32'h0BAD_F00D;
      end
      if (push) begin
         e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
         e.rdata = (!w && !e.err) ? model[a[7:2]] : 32'h0;
         if (w && !e.err) model[a[7:2]] = d;
         sb.push_back(e);
      end
   endtask

   // Wait for the response, stall it for 'hold' cycles, then handshake.
   task automatic wait_rsp(input int hold);
      int   lat = 1;
      exp_t e;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         if (junk_on) req_valid = ~req_valid;
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      check("rsp_latency", 32'(lat), 32'(LAT + 1));
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         e.rdata = 32'h0;
         e.err   = 1'b0;
      end else begin
         e = sb.pop_front();
      end
      rsp_ready = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, e.rdata);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("post_hs_req_ready", 32'(req_ready), 32'd1);
      check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rel_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("rel_ready_high", 32'(req_ready), 32'd1);

      // Store then load the same word.
      send(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1); wait_rsp(0);
      send(1'b0, 32'h10, 32'h0, 1'b1);         wait_rsp(0);

      // Misaligned and out-of-range requests leave the array untouched.
      send(1'b1, 32'h0,   32'hA5A5_A5A5, 1'b1); wait_rsp(0);
      send(1'b0, 32'h13,  32'h0, 1'b1);         wait_rsp(0);
      send(1'b1, 32'h100, 32'h5, 1'b1);         wait_rsp(0);
      send(1'b0, 32'h0,   32'h0, 1'b1);         wait_rsp(0);

      // Stalled response, with junk requests driven while waiting.
      junk_on = 1'b1;
      send(1'b0, 32'h10, 32'h0, 1'b1); wait_rsp(5);
      junk_on = 1'b0;
      send(1'b0, 32'h10, 32'h0, 1'b1); wait_rsp(0);

      // Reset in WAIT aborts a store.
      send(1'b1, 32'h20, 32'h1111_0000, 1'b1); wait_rsp(0);
      send(1'b1, 32'h20, 32'h0000_1234, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'd0);
      check("abort_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;
      check("abort_hold_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      send(1'b0, 32'h20, 32'h0, 1'b1); wait_rsp(0);

      // LATENCY=0 instance: store, then back-to-back loads.
      z_rsp_ready = 1'b1;
      z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'hCAFE_0004;
      n = 0;
      while (z_req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("z_accept_wait", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      z_req_write = 1'b0;
      check("z_store_valid", 32'(z_rsp_valid), 32'd1);
      check("z_store_ready", 32'(z_req_ready), 32'd0);
      @(posedge clk); #1;
      check("z_store_done", 32'(z_rsp_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("z_ready_idle", 32'(z_req_ready), 32'd1);
         @(posedge clk); #1;
         check("z_load_valid", 32'(z_rsp_valid), 32'd1);
         check("z_load_rdata", z_rsp_rdata, 32'hCAFE_0004);
         check("z_load_err", 32'(z_rsp_err), 32'd0);
         check("z_busy", 32'(z_req_ready), 32'd0);
         @(posedge clk); #1;
         check("z_load_done", 32'(z_rsp_valid), 32'd0);
      end
      z_req_valid = 1'b0;

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
